// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash read responder: FSM states, flash
// command opcodes and the fast-read dummy clock count.
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE,
    CS_HOLD
  } flash_state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [4:0] DUMMY_CLKS    = 5'd8;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI mode-0 clock generator: half-period of CLK_DIV system cycles, with
// one-cycle strobes marking the system edge on which sclk rises or falls.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic       w_edge;

  assign w_edge = i_run && (r_cnt == DIV_LAST);
  assign o_rise = w_edge && !r_sclk;
  assign o_fall = w_edge && r_sclk;
  assign o_sclk = r_sclk;

  // Dropping run parks the clock low and restarts the half-period count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (r_cnt == DIV_LAST) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/flash_spi_responder.sv
// Avalon-MM read slave that fetches one 32-bit word per request from a SPI
// flash. Define FLASH_FAST_READ_EN to use command 0x0B with 8 dummy clocks.
module flash_spi_responder
  import flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        fetch_clock,
  input  logic        reset_n,
  input  logic        flash_mem_read,
  input  logic [22:0] flash_mem_address,
  output logic        flash_mem_waitrequest,
  output logic [31:0] flash_mem_readdata,
  output logic        flash_mem_readdatavalid,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0]   READ_CMD   = CMD_FAST_READ;
  localparam flash_state_t AFTER_ADDR = DUMMY;
`else
  localparam logic [7:0]   READ_CMD   = CMD_READ;
  localparam flash_state_t AFTER_ADDR = DATA;
`endif

  localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 1);

  flash_state_t r_state;
  logic         r_wait;
  logic         r_valid;
  logic         r_cs_n;
  logic [31:0]  r_rdata;
  logic [31:0]  r_tx;
  logic [31:0]  r_rx;
  logic [4:0]   r_bitcnt;
  logic [8:0]   r_hold;

  logic         w_run;
  logic         w_rise;
  logic         w_fall;
  logic         w_accept;
  logic [23:0]  w_byte_addr;
  logic         w_unused_addr_msb;

  // The byte address is 24 bits; the word address MSB falls off the top.
  assign w_byte_addr       = {flash_mem_address[21:0], 2'b00};
  assign w_unused_addr_msb = flash_mem_address[22];

  assign w_accept = (r_state == IDLE) && flash_mem_read && !r_wait;
  assign w_run    = !r_cs_n && (r_state inside {CMD, ADDR, DUMMY, DATA});

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk   (fetch_clock),
    .i_rst_n (reset_n),
    .i_run   (w_run),
    .o_sclk  (spi_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge fetch_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_wait   <= 1'b1;
      r_valid  <= 1'b0;
      r_cs_n   <= 1'b1;
      r_rdata  <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_bitcnt <= '0;
      r_hold   <= '0;
    end else begin
      r_valid <= 1'b0;
      // Command and address share one shifter; it drains to zero for the tail.
      if (w_fall) begin
        r_tx     <= {r_tx[30:0], 1'b0};
        r_bitcnt <= r_bitcnt + 5'd1;
      end
      if (w_rise && (r_state == DATA))
        r_rx <= {r_rx[30:0], spi_miso};

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= CMD;
            r_wait   <= 1'b1;
            r_cs_n   <= 1'b0;
            r_tx     <= {READ_CMD, w_byte_addr};
            r_bitcnt <= '0;
          end else begin
            r_wait <= 1'b0;
          end
        end
        CMD: begin
          if (w_fall && (r_bitcnt == 5'd7)) begin
            r_state  <= ADDR;
            r_bitcnt <= '0;
          end
        end
        ADDR: begin
          if (w_fall && (r_bitcnt == 5'd23)) begin
            r_state  <= AFTER_ADDR;
            r_bitcnt <= '0;
          end
        end
        DUMMY: begin
          if (w_fall && (r_bitcnt == DUMMY_CLKS - 5'd1)) begin
            r_state  <= DATA;
            r_bitcnt <= '0;
          end
        end
        DATA: begin
          if (w_fall && (r_bitcnt == 5'd31)) begin
            r_state  <= DONE;
            r_bitcnt <= '0;
          end
        end
        DONE: begin
          // First byte off the wire lands in the low byte of the word.
          r_rdata <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
          r_valid <= 1'b1;
          r_cs_n  <= 1'b1;
          r_hold  <= '0;
          r_state <= CS_HOLD;
        end
        CS_HOLD: begin
          if (r_hold == HOLD_LAST) begin
            r_state <= IDLE;
            r_wait  <= 1'b0;
          end else begin
            r_hold <= r_hold + 9'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flash_mem_waitrequest   = r_wait;
  assign flash_mem_readdata      = r_rdata;
  assign flash_mem_readdatavalid = r_valid;
  assign spi_cs_n                = r_cs_n;
  assign spi_mosi                = r_tx[31];

endmodule

// File: tb/tb_flash_spi_responder.sv
// Directed bench for flash_spi_responder with a behavioural SPI flash model.
// Builds with CLK_DIV=2 normally, CLK_DIV=1 when FLASH_FAST_READ_EN is defined.
module tb_flash_spi_responder;

`ifdef FLASH_FAST_READ_EN
  localparam int         CD      = 1;
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int         HDR     = 40;
`else
  localparam int         CD      = 2;
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int         HDR     = 32;
`endif
  localparam int LAT   = 2 * CD * (HDR + 32) + 2;
  localparam int RISES = HDR + 32;

  logic        fetch_clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        flash_mem_read = 1'b0;
  logic [22:0] flash_mem_address = '0;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  flash_spi_responder #(.CLK_DIV(CD)) dut (
    .fetch_clock             (fetch_clock),
    .reset_n                 (reset_n),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .spi_cs_n                (spi_cs_n),
    .spi_sclk                (spi_sclk),
    .spi_mosi                (spi_mosi),
    .spi_miso                (spi_miso)
  );

  always #5 fetch_clock = ~fetch_clock;

  // Flash model: captures cmd+addr on sclk rises, shifts data out on falls.
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  int          rcnt = 0;
  int          last_rises = 0;
  int          jbit = 0;
  logic [31:0] cap = '0;
  logic [31:0] cur = '0;
  logic [31:0] flash_words[$];

  always @(negedge fetch_clock) begin
    if (!spi_cs_n && prev_cs) begin
      rcnt = 0;
      cap  = '0;
      if (flash_words.size() > 0) cur = flash_words.pop_front();
      else cur = '0;
    end
    if (spi_cs_n && !prev_cs) last_rises = rcnt;
    if (!spi_cs_n) begin
      if (spi_sclk && !prev_sclk) begin
        if (rcnt < 32) cap = {cap[30:0], spi_mosi};
        rcnt++;
      end
      if (!spi_sclk && prev_sclk) begin
        jbit = rcnt - HDR;
        if (jbit >= 0 && jbit < 32) spi_miso = cur[31 - jbit];
        else spi_miso = 1'b0;
      end
    end else begin
      spi_miso = 1'b0;
    end
    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic do_read(input logic [22:0] a, input logic [31:0] stream, input bit alter,
                         output int lat, output logic [31:0] word, output logic v_after);
    int n;
    flash_words.push_back(stream);
    lat = -1;
    word = '0;
    v_after = 1'bx;
    @(negedge fetch_clock);
    flash_mem_read = 1'b1;
    flash_mem_address = a;
    n = 0;
    while (flash_mem_waitrequest && n < 50) begin
      @(negedge fetch_clock);
      n++;
    end
    if (flash_mem_waitrequest) begin
      flash_mem_read = 1'b0;
      return;
    end
    @(posedge fetch_clock);
    #1;
    if (alter) flash_mem_address = 23'h000020;
    else flash_mem_read = 1'b0;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge fetch_clock);
      if (alter && k == 10) flash_mem_read = 1'b0;
      if (flash_mem_readdatavalid) begin
        lat = k;
        word = flash_mem_readdata;
        break;
      end
    end
    @(negedge fetch_clock);
    v_after = flash_mem_readdatavalid;
    repeat (3) @(negedge fetch_clock);
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    repeat (3) @(negedge fetch_clock);
    vectors++; if (spi_cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
    vectors++; if (spi_sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", spi_sclk); end
    vectors++; if (spi_mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
    vectors++; if (flash_mem_waitrequest !== 1'b1) begin miscompares++; $display("FAIL reset_wait: got %b expected 1", flash_mem_waitrequest); end
    vectors++; if (flash_mem_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", flash_mem_readdatavalid); end
    vectors++; if (flash_mem_readdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 00000000", flash_mem_readdata); end
    reset_n = 1'b1;
    @(negedge fetch_clock);
    vectors++; if (flash_mem_waitrequest !== 1'b0) begin miscompares++; $display("FAIL release_wait: got %b expected 0", flash_mem_waitrequest); end
  endtask

  task automatic test_basic_read();
    int lat; logic [31:0] w; logic va;
    do_read(23'h000001, 32'h11223344, 1'b0, lat, w, va);
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    vectors++; if (w !== 32'h44332211) begin miscompares++; $display("FAIL basic_rdata: got %h expected 44332211", w); end
    vectors++; if (cap !== {EXP_CMD, 24'h000004}) begin miscompares++; $display("FAIL basic_mosi: got %h expected %h", cap, {EXP_CMD, 24'h000004}); end
    vectors++; if (last_rises !== RISES) begin miscompares++; $display("FAIL basic_sclk_count: got %0d expected %0d", last_rises, RISES); end
    vectors++; if (va !== 1'b0) begin miscompares++; $display("FAIL basic_valid_width: got %b expected 0", va); end
    vectors++; if (flash_mem_readdata !== 32'h44332211) begin miscompares++; $display("FAIL basic_rdata_hold: got %h expected 44332211", flash_mem_readdata); end
  endtask

  task automatic test_back_to_back();
    int v1, v2, acc2, hold, n;
    logic [31:0] w1, w2;
    v1 = -1; v2 = -1; acc2 = -1; hold = 0; w1 = '0; w2 = '0;
    flash_words.push_back(32'h01020304);
    flash_words.push_back(32'hDEADBEEF);
    @(negedge fetch_clock);
    flash_mem_read = 1'b1;
    flash_mem_address = 23'h000100;
    n = 0;
    while (flash_mem_waitrequest && n < 50) begin @(negedge fetch_clock); n++; end
    @(posedge fetch_clock);
    for (int k = 1; k <= 2 * LAT + 60; k++) begin
      @(negedge fetch_clock);
      if (flash_mem_readdatavalid) begin
        if (v1 < 0) begin v1 = k; w1 = flash_mem_readdata; end
        else if (v2 < 0) begin v2 = k; w2 = flash_mem_readdata; end
      end
      if (acc2 < 0 && v1 > 0 && flash_mem_waitrequest && spi_cs_n) hold++;
      if (acc2 < 0 && v1 > 0 && !flash_mem_waitrequest) begin
        acc2 = k;
        @(posedge fetch_clock);
        #1 flash_mem_read = 1'b0;
      end
      if (v2 > 0) break;
    end
    flash_mem_read = 1'b0;
    vectors++; if (v1 !== LAT) begin miscompares++; $display("FAIL b2b_valid1: got %0d expected %0d", v1, LAT); end
    vectors++; if (hold !== 2 * CD) begin miscompares++; $display("FAIL b2b_cs_hold: got %0d expected %0d", hold, 2 * CD); end
    vectors++; if (acc2 !== LAT + 2 * CD) begin miscompares++; $display("FAIL b2b_accept2: got %0d expected %0d", acc2, LAT + 2 * CD); end
    vectors++; if (v2 !== 2 * LAT + 2 * CD) begin miscompares++; $display("FAIL b2b_valid2: got %0d expected %0d", v2, 2 * LAT + 2 * CD); end
    vectors++; if (w1 !== 32'h04030201) begin miscompares++; $display("FAIL b2b_word1: got %h expected 04030201", w1); end
    vectors++; if (w2 !== 32'hEFBEADDE) begin miscompares++; $display("FAIL b2b_word2: got %h expected efbeadde", w2); end
    repeat (8) @(negedge fetch_clock);
  endtask

  task automatic test_reset_mid_data();
    int n, vcnt, lat; logic [31:0] w; logic va;
    flash_words.push_back(32'hCAFEF00D);
    @(negedge fetch_clock);
    flash_mem_read = 1'b1;
    flash_mem_address = 23'h000055;
    n = 0;
    while (flash_mem_waitrequest && n < 50) begin @(negedge fetch_clock); n++; end
    @(posedge fetch_clock);
    #1 flash_mem_read = 1'b0;
    repeat (2 * CD * (HDR + 16)) @(negedge fetch_clock);
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (spi_cs_n !== 1'b1) begin miscompares++; $display("FAIL abort_cs_n: got %b expected 1", spi_cs_n); end
    vectors++; if (spi_sclk !== 1'b0) begin miscompares++; $display("FAIL abort_sclk: got %b expected 0", spi_sclk); end
    vectors++; if (flash_mem_waitrequest !== 1'b1) begin miscompares++; $display("FAIL abort_wait: got %b expected 1", flash_mem_waitrequest); end
    vectors++; if (flash_mem_readdata !== 32'h0) begin miscompares++; $display("FAIL abort_rdata: got %h expected 00000000", flash_mem_readdata); end
    @(negedge fetch_clock);
    reset_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge fetch_clock);
      if (flash_mem_readdatavalid) vcnt++;
    end
    vectors++; if (vcnt !== 0) begin miscompares++; $display("FAIL abort_no_valid: got %0d strobes expected 0", vcnt); end
    do_read(23'h0ABCDE, 32'h5A6B7C8D, 1'b0, lat, w, va);
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL after_abort_latency: got %0d expected %0d", lat, LAT); end
    vectors++; if (w !== 32'h8D7C6B5A) begin miscompares++; $display("FAIL after_abort_rdata: got %h expected 8d7c6b5a", w); end
    vectors++; if (cap !== {EXP_CMD, 24'h2AF378}) begin miscompares++; $display("FAIL after_abort_mosi: got %h expected %h", cap, {EXP_CMD, 24'h2AF378}); end
  endtask

  task automatic test_addr_change();
    int lat; logic [31:0] w; logic va;
    do_read(23'h000010, 32'h0F1E2D3C, 1'b1, lat, w, va);
    vectors++; if (cap !== {EXP_CMD, 24'h000040}) begin miscompares++; $display("FAIL addr_latch_mosi: got %h expected %h", cap, {EXP_CMD, 24'h000040}); end
    vectors++; if (w !== 32'h3C2D1E0F) begin miscompares++; $display("FAIL addr_latch_rdata: got %h expected 3c2d1e0f", w); end
    vectors++; if (va !== 1'b0) begin miscompares++; $display("FAIL addr_latch_single: got %b expected 0", va); end
  endtask

  task automatic test_top_address();
    int lat; logic [31:0] w; logic va;
    do_read(23'h7FFFFF, 32'hA5C30F81, 1'b0, lat, w, va);
    vectors++; if (cap !== {EXP_CMD, 24'hFFFFFC}) begin miscompares++; $display("FAIL top_addr_mosi: got %h expected %h", cap, {EXP_CMD, 24'hFFFFFC}); end
    vectors++; if (w !== 32'h810FC3A5) begin miscompares++; $display("FAIL top_addr_rdata: got %h expected 810fc3a5", w); end
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL top_addr_latency: got %0d expected %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_reset_mid_data();
    test_addr_change();
    test_top_address();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flash_spi_responder.md
FLASH_SPI_RESPONDER -- requirements
Module: flash_spi_responder

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning the number of fetch_clock cycles per SPI clock half-period (legal range 1..255).
REQ-002 SHALL have port fetch_clock  input  1  system clock, all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flash_mem_read  input  1  Avalon-MM read request.
REQ-005 SHALL have port flash_mem_address  input  23  Avalon word address; byte address is {address, 2'b00}, 24 bits wide.
REQ-006 SHALL have port flash_mem_waitrequest  output  1  request stall.
REQ-007 SHALL have port flash_mem_readdata  output  32  returned word.
REQ-008 SHALL have port flash_mem_readdatavalid  output  1  one-cycle data-valid strobe.
REQ-009 SHALL have port spi_cs_n  output  1  flash chip select, active low.
REQ-010 SHALL have port spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-011 SHALL have port spi_mosi  output  1  serial data to flash, MSB first.
REQ-012 SHALL have port spi_miso  input  1  serial data from flash.

Function
REQ-013 SHALL use the FSM states IDLE, CMD, ADDR, DATA, DONE and CS_HOLD.
REQ-014 SHALL drive waitrequest low only in IDLE; a read is accepted on an edge where flash_mem_read=1 and waitrequest=0, and the FSM then moves to CMD.
REQ-015 SHALL latch the address at acceptance and ignore later changes to flash_mem_address and flash_mem_read until the FSM returns to IDLE.
REQ-016 SHALL assert spi_cs_n low on the cycle after acceptance and keep it low through DATA.
REQ-017 SHALL shift out, MSB first: command byte 0x03 (CMD, 8 bits), then the 24-bit byte address (ADDR), then receive 32 bits (DATA).
REQ-018 SHALL change spi_mosi on falling sclk edges and sample spi_miso on rising sclk edges; each bit SHALL span exactly 2*CLK_DIV fetch_clock cycles.
REQ-019 SHALL pack the received data little-endian: 1st byte -> readdata[7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24]; bit order within each byte is MSB first.
REQ-020 SHALL update readdata and pulse readdatavalid for exactly one cycle in DONE.
REQ-021 SHALL pulse readdatavalid exactly 128*CLK_DIV+2 cycles after the acceptance edge (plus the fast-read extension in REQ-029).
REQ-022 SHALL hold readdata stable between strobes.
REQ-023 SHALL, in CS_HOLD, keep spi_cs_n high for 2*CLK_DIV cycles and then return to IDLE.
REQ-024 SHALL never issue back-to-back requests without a CS_HOLD period between them.
REQ-025 SHALL keep the byte address a plain 24-bit value with no wrap; word address 0x7FFFFF maps to byte address 0xFFFFFC.

Reset
REQ-026 SHALL, while reset_n=0, immediately force: state=IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, waitrequest=1, readdatavalid=0, readdata=0.
REQ-027 SHALL drive waitrequest low on the first rising edge after reset_n deasserts.
REQ-028 SHALL, on reset mid-transaction, abort the transaction: no readdatavalid pulse and no later completion of the aborted read.

Configuration
REQ-029 SHALL, when FLASH_FAST_READ_EN is defined, use command 0x0B and insert 8 dummy SPI clocks between ADDR and DATA; readdatavalid latency becomes 144*CLK_DIV+2.
REQ-030 SHALL, when FLASH_FAST_READ_EN is undefined, use command 0x03 with no dummy clocks, as in REQ-017 and REQ-021.

Structure
REQ-031 SHALL take the state enum, the command constants (0x03, 0x0B) and the dummy-cycle count from shared package flash_pkg.
REQ-032 SHALL instantiate sub-module spi_clk_gen, which generates spi_sclk plus one-cycle rise/fall enable strobes from CLK_DIV and runs only when spi_cs_n=0.

Verification
REQ-033 SHALL verify: CLK_DIV=2, read at address 0x000001, flash model returning bytes 11 22 33 44 -> MOSI carries 0x03,0x00,0x00,0x04; readdata=0x44332211; valid at acceptance+258.
REQ-034 SHALL verify: read held high continuously for two requests -> second acceptance occurs only after CS_HOLD (cs_n high for 4 cycles); both words are correct and in order.
REQ-035 SHALL verify: reset_n pulsed low during DATA -> cs_n high and sclk low at once; no valid strobe; the next read completes normally.
REQ-036 SHALL verify: address changed mid-transaction from 0x000010 to 0x000020 -> MOSI still carries byte address 0x000040.
REQ-037 SHALL verify: FLASH_FAST_READ_EN defined, CLK_DIV=1 -> command 0x0B, 8 dummy clocks, valid at acceptance+146.
REQ-038 SHALL verify: address 0x7FFFFF -> MOSI carries byte address 0xFFFFFC; readdata is correct.
